// File: rtl/debounce_pkg.sv
// Shared constants, channel bundle and width helper for the button debouncer.
// Imported by debounce_channel and multi_button_debouncer.
package debounce_pkg;

  localparam int DEB_10MS_100MHZ = 1_000_000;
  localparam int HOLD_500MS      = 50_000_000;
  localparam int REPEAT_100MS    = 10_000_000;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic rpt;
  } chOut_t;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop sync, stable-window filter, edge pulses,
// optional auto-repeat (macro AUTO_REPEAT_EN).
// Ports: clk, rstN (sync, active low), inBit (pressed = 1), chOut bundle.
module debounce_channel
  import debounce_pkg::*;
#(
`ifdef AUTO_REPEAT_EN
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS,
`endif
  parameter int DEBOUNCE_CYCLES = DEB_10MS_100MHZ
) (
  input  logic   clk,
  input  logic   rstN,
  input  logic   inBit,
  output chOut_t chOut
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          level;
  logic          press;
  logic          rel;
  logic          flip;

  // Window complete: level changes on this edge.
  assign flip = (sync2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= inBit;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      unique case (1'b1)
        (sync2 == level): cnt <= '0;
        flip: begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
          rel   <= ~sync2;
        end
        default: cnt <= cnt + 1'b1;
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HW = clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_RELOAD =
    HW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [HW-1:0] hold;
  logic          rpt;
  logic          held;

  // Held means pressed now and not releasing on this edge,
  // so a release always wins over a due repeat.
  assign held = level && !flip;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      hold <= '0;
      rpt  <= 1'b0;
    end else begin
      rpt <= 1'b0;
      unique case (1'b1)
        (!held): hold <= '0;
        (hold == HOLD_LAST): begin
          hold <= HOLD_RELOAD;
          rpt  <= 1'b1;
        end
        default: hold <= hold + 1'b1;
      endcase
    end
  end

  assign chOut = '{level: level, press: press,
                   rel: rel, rpt: rpt};
`else
  assign chOut = '{level: level, press: press,
                   rel: rel, rpt: 1'b0};
`endif

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button/switch debouncer: polarity fix and port packing.
// Ports: clk, rstN, rawIn, debouncedOut, press/release/repeatPulse.
// Macro AUTO_REPEAT_EN enables hold-to-repeat pulses.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = DEB_10MS_100MHZ,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [NUM_CH-1:0] rawIn,
  output logic [NUM_CH-1:0] debouncedOut,
  output logic [NUM_CH-1:0] pressPulse,
  output logic [NUM_CH-1:0] releasePulse,
  output logic [NUM_CH-1:0] repeatPulse
);

  localparam logic INV = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      REPEAT_CYCLES > HOLD_CYCLES) begin : gBadCfg
    $error("multi_button_debouncer: bad timing params");
  end

  logic [NUM_CH-1:0] padIn;

  // Pressed is 1 internally whatever the pad polarity.
  assign padIn = rawIn ^ {NUM_CH{INV}};

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    chOut_t o;

    debounce_channel #(
`ifdef AUTO_REPEAT_EN
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
`endif
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uCh (
      .clk  (clk),
      .rstN (rstN),
      .inBit(padIn[i]),
      .chOut(o)
    );

    assign debouncedOut[i] = o.level;
    assign pressPulse[i]   = o.press;
    assign releasePulse[i] = o.rel;
    assign repeatPulse[i]  = o.rpt;
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer (DEB=4, HOLD=20, REP=8).
// Repeat expectations follow AUTO_REPEAT_EN.
module tb_multi_button_debouncer;

`ifdef AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clk;
  logic       rstN;
  logic [3:0] rawIn;
  logic [3:0] debouncedOut;
  logic [3:0] pressPulse;
  logic [3:0] releasePulse;
  logic [3:0] repeatPulse;

  int nCmp;
  int nErr;
  int pressCnt[4];
  int relCnt[4];
  int rptCnt[4];
  int overlapCnt;

  multi_button_debouncer #(
    .NUM_CH         (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (0),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .rawIn       (rawIn),
    .debouncedOut(debouncedOut),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .repeatPulse (repeatPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies; values read at posedge are the previous cycle's.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pressPulse[i])   pressCnt[i]++;
      if (releasePulse[i]) relCnt[i]++;
      if (repeatPulse[i])  rptCnt[i]++;
    end
    if ((pressPulse & releasePulse) != 4'h0) overlapCnt++;
  end

  task automatic adv(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkAll0(input string tag);
    chk({tag, ".deb"}, 32'(debouncedOut), 0);
    chk({tag, ".prs"}, 32'(pressPulse), 0);
    chk({tag, ".rel"}, 32'(releasePulse), 0);
    chk({tag, ".rpt"}, 32'(repeatPulse), 0);
  endtask

  initial begin
    logic [5:0] bounce;
    bit         due;
    nCmp = 0;
    nErr = 0;
    overlapCnt = 0;
    for (int i = 0; i < 4; i++) begin
      pressCnt[i] = 0;
      relCnt[i]   = 0;
      rptCnt[i]   = 0;
    end
    rstN  = 1'b0;
    rawIn = 4'hF;

    // Reset with all inputs active.
    adv(3);
    chkAll0("rst");
    rstN = 1'b1;
    adv(5);
    chk("rst+5.deb", 32'(debouncedOut), 32'h0);
    chk("rst+5.prs", 32'(pressPulse), 32'h0);
    adv(1);
    chk("rst+6.deb", 32'(debouncedOut), 32'hF);
    chk("rst+6.prs", 32'(pressPulse), 32'hF);
    chk("rst+6.rel", 32'(releasePulse), 32'h0);
    adv(1);
    chk("rst+7.prs", 32'(pressPulse), 32'h0);
    chk("rst+7.deb", 32'(debouncedOut), 32'hF);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rst.once%0d", i), 32'(pressCnt[i]), 1);
    rawIn = 4'h0;
    adv(7);
    chk("rel.all", 32'(debouncedOut), 32'h0);

    // Clean press on ch0.
    rawIn = 4'h1;
    adv(5);
    chk("p0+5.deb", 32'(debouncedOut), 32'h0);
    adv(1);
    chk("p0+6.deb", 32'(debouncedOut), 32'h1);
    chk("p0+6.prs", 32'(pressPulse), 32'h1);
    adv(1);
    chk("p0+7.prs", 32'(pressPulse), 32'h0);
    chk("p0+7.deb", 32'(debouncedOut), 32'h1);

    // ch0 release together with ch3 press.
    rawIn = 4'h8;
    adv(5);
    chk("sim+5.deb", 32'(debouncedOut), 32'h1);
    chk("sim+5.rel", 32'(releasePulse), 32'h0);
    adv(1);
    chk("sim+6.rel", 32'(releasePulse), 32'h1);
    chk("sim+6.prs", 32'(pressPulse), 32'h8);
    chk("sim+6.deb", 32'(debouncedOut), 32'h8);
    adv(1);
    chk("sim+7.rel", 32'(releasePulse), 32'h0);
    chk("sim+7.prs", 32'(pressPulse), 32'h0);
    rawIn = 4'h0;
    adv(7);
    chk("sim.idle", 32'(debouncedOut), 32'h0);

    // Bouncing press on ch1: 1,0,1,1,0 then steady 1.
    bounce = 6'b101101;
    for (int j = 0; j < 6; j++) begin
      rawIn[1] = bounce[j];
      if (j < 5) adv(1);
    end
    adv(5);
    chk("bn+5.deb", 32'(debouncedOut), 32'h0);
    chk("bn+5.prs", 32'(pressPulse), 32'h0);
    adv(1);
    chk("bn+6.deb", 32'(debouncedOut), 32'h2);
    chk("bn+6.prs", 32'(pressPulse), 32'h2);
    chk("bn+6.rel", 32'(releasePulse), 32'h0);

    // Hold ch1; debounced release lands on press+60.
    for (int k = 1; k <= 60; k++) begin
      adv(1);
      due = RPT && (k == 20 || k == 28 || k == 36 ||
                    k == 44 || k == 52);
      chk($sformatf("hold%0d.rpt", k),
          32'(repeatPulse), due ? 32'h2 : 32'h0);
      chk($sformatf("hold%0d.prs", k),
          32'(pressPulse), 32'h0);
      chk($sformatf("hold%0d.deb", k),
          32'(debouncedOut), (k < 60) ? 32'h2 : 32'h0);
      if (k == 54) rawIn[1] = 1'b0;
    end
    chk("hold.rel", 32'(releasePulse), 32'h2);
    for (int k = 1; k <= 10; k++) begin
      adv(1);
      chk($sformatf("post%0d.rpt", k),
          32'(repeatPulse), 32'h0);
    end

    // Short glitch on ch2.
    rawIn[2] = 1'b1;
    adv(3);
    rawIn[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      adv(1);
      chk($sformatf("gl%0d.deb", k),
          32'(debouncedOut), 32'h0);
      chk($sformatf("gl%0d.prs", k),
          32'(pressPulse), 32'h0);
    end

    // Reset in the middle of a window.
    rawIn = 4'h4;
    adv(4);
    rstN = 1'b0;
    adv(2);
    chkAll0("midrst");
    rstN  = 1'b1;
    rawIn = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      adv(1);
      chk($sformatf("ar%0d.deb", k),
          32'(debouncedOut), 32'h0);
      chk($sformatf("ar%0d.prs", k),
          32'(pressPulse), 32'h0);
    end

    // Pulse totals over the whole run.
    adv(2);
    chk("tot.prs0", 32'(pressCnt[0]), 2);
    chk("tot.prs1", 32'(pressCnt[1]), 2);
    chk("tot.prs2", 32'(pressCnt[2]), 1);
    chk("tot.prs3", 32'(pressCnt[3]), 2);
    chk("tot.rel0", 32'(relCnt[0]), 2);
    chk("tot.rel1", 32'(relCnt[1]), 2);
    chk("tot.rel2", 32'(relCnt[2]), 1);
    chk("tot.rel3", 32'(relCnt[3]), 2);
    chk("tot.rpt0", 32'(rptCnt[0]), 0);
    chk("tot.rpt1", 32'(rptCnt[1]), RPT ? 5 : 0);
    chk("tot.rpt2", 32'(rptCnt[2]), 0);
    chk("tot.rpt3", 32'(rptCnt[3]), 0);
    chk("overlap", 32'(overlapCnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
